// File: rtl/pe_feeder.sv
// Operand launcher for an NxN systolic PE array: accepts one k-step per handshake,
// skews A rows / B columns diagonally onto the array edges and signals when all sums are final.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module pe_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  last_i,
  input  logic [N*DATA_WIDTH-1:0] a_vec_i,
  input  logic [N*DATA_WIDTH-1:0] b_vec_i,
  output logic [N*DATA_WIDTH-1:0] srca_o,
  output logic [N-1:0]          clear_o,
  output logic [N*DATA_WIDTH-1:0] srcb_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(2 * N - 1);

  // Handshake: a k-step transfers on a rising edge where in_valid_i & in_ready_o;
  // a_vec_i, b_vec_i and last_i are sampled only on that edge. No back-pressure from the array.
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic            accept;

  logic [N*DATA_WIDTH-1:0] la_q;
  logic [N*DATA_WIDTH-1:0] lb_q;
  logic                    lf_q;

  assign in_ready_o = (state_q != S_DRAIN);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FEED: begin
          if (accept) begin
            if (last_i) begin
              state_q <= S_DRAIN;
              cnt_q   <= DRAIN_LOAD;
            end else begin
              state_q <= S_FEED;
            end
          end
        end
        S_DRAIN: begin
          // Counter spans the skew plus PE pipeline so done lands as PE(N-1,N-1) settles.
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Launch stage: accepted vectors, otherwise zero bubbles so stalls add nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      la_q <= '0;
      lb_q <= '0;
      lf_q <= 1'b0;
    end else if (accept) begin
      la_q <= a_vec_i;
      lb_q <= b_vec_i;
      lf_q <= (state_q == S_IDLE);
    end else begin
      la_q <= '0;
      lb_q <= '0;
      lf_q <= 1'b0;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign srca_o[0 +: DATA_WIDTH] = la_q[0 +: DATA_WIDTH];
      assign clear_o[0]              = lf_q;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] a_d [1:r];
      logic                  c_d [1:r];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int s = 1; s <= r; s++) begin
            a_d[s] <= '0;
            c_d[s] <= 1'b0;
          end
        end else begin
          a_d[1] <= la_q[r*DATA_WIDTH +: DATA_WIDTH];
          c_d[1] <= lf_q;
          for (int s = 2; s <= r; s++) begin
            a_d[s] <= a_d[s-1];
            c_d[s] <= c_d[s-1];
          end
        end
      end
      assign srca_o[r*DATA_WIDTH +: DATA_WIDTH] = a_d[r];
      assign clear_o[r]                         = c_d[r];
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    if (c == 0) begin : g_direct
      assign srcb_o[0 +: DATA_WIDTH] = lb_q[0 +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] b_d [1:c];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int s = 1; s <= c; s++) b_d[s] <= '0;
        end else begin
          b_d[1] <= lb_q[c*DATA_WIDTH +: DATA_WIDTH];
          for (int s = 2; s <= c; s++) b_d[s] <= b_d[s-1];
        end
      end
      assign srcb_o[c*DATA_WIDTH +: DATA_WIDTH] = b_d[c];
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: per-edge expected edge-of-array outputs derived
// from a log of accepted beats (beat at edge E shows on row r / column c after edge E+r / E+c).
module tb_pe_feeder;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int W    = 2 * N * DW + N + 3;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic last = 1'b0;
  logic [N*DW-1:0] a_vec = '0;
  logic [N*DW-1:0] b_vec = '0;
  logic in_ready, busy, done;
  logic [N*DW-1:0] srca, srcb;
  logic [N-1:0] clear;

  always #5 clk = ~clk;

  pe_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .last_i(last), .a_vec_i(a_vec), .b_vec_i(b_vec), .srca_o(srca),
    .clear_o(clear), .srcb_o(srcb), .busy_o(busy), .done_o(done)
  );

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edge counter, accepted-beat log, product bookkeeping.
  int cyc = 0;
  int rst_edge = 0;
  int e_last = -1000;
  bit in_prod = 1'b0;
  bit m_acc = 1'b0;
  logic [N*DW-1:0] rec_a [MAXC];
  logic [N*DW-1:0] rec_b [MAXC];
  bit              rec_v [MAXC];
  bit              rec_c [MAXC];

  function automatic logic [W-1:0] expect_after(int n);
    logic [N*DW-1:0] ea;
    logic [N*DW-1:0] eb;
    logic [N-1:0]    ec;
    bit drain;
    bit fin;
    ea = '0; eb = '0; ec = '0;
    for (int r = 0; r < N; r++) begin
      int idx;
      idx = n - r;
      if (idx > rst_edge && idx >= 0 && rec_v[idx]) begin
        ea[r*DW +: DW] = rec_a[idx][r*DW +: DW];
        eb[r*DW +: DW] = rec_b[idx][r*DW +: DW];
        ec[r]          = rec_c[idx];
      end
    end
    drain = (e_last <= n) && (n <= e_last + 2*N - 1);
    fin   = (n == e_last + 2*N);
    return {ea, eb, ec, !drain, in_prod || drain, fin};
  endfunction

  task automatic model_edge();
    bit ready_before;
    cyc++;
    if (!rst_n) begin
      rst_edge = cyc;
      e_last   = -1000;
      in_prod  = 1'b0;
      m_acc    = 1'b0;
      rec_v[cyc] = 1'b0;
    end else begin
      ready_before = !((e_last <= cyc - 1) && (cyc - 1 <= e_last + 2*N - 1));
      m_acc = in_valid && ready_before;
      rec_v[cyc] = m_acc;
      if (m_acc) begin
        rec_a[cyc] = a_vec;
        rec_b[cyc] = b_vec;
        rec_c[cyc] = !in_prod;
        if (last) begin
          e_last  = cyc;
          in_prod = 1'b0;
        end else begin
          in_prod = 1'b1;
        end
      end
    end
    exp_q.push_back(expect_after(cyc));
    cyc_q.push_back(cyc);
  endtask

  task automatic check(input string name, input int n, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h required %h", name, n, got, exp);
  endtask

  // Monitor: compares the DUT against the queued expectation one time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        int n;
        e = exp_q.pop_front();
        n = cyc_q.pop_front();
        check("outputs", n, {srca, srcb, clear, in_ready, busy, done}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) tick();
  endtask

  task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                           input bit lst);
    in_valid = 1'b1; a_vec = a; b_vec = b; last = lst;
    m_acc = 1'b0;
    for (int i = 0; i < 4*N; i++) begin
      tick();
      if (m_acc) break;
    end
    if (!m_acc) begin
      n_checks++;
      $display("FAIL accept_timeout cycle %0d: got no acceptance required one", cyc);
    end
    in_valid = 1'b0; a_vec = '0; b_vec = '0; last = 1'b0;
  endtask

  task automatic ident_product(input int stall, input bit neg, input int nbeats);
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    for (int k = 0; k < nbeats; k++) begin
      if (k == 2) idle(stall);
      for (int r = 0; r < N; r++) begin
        logic [DW-1:0] av;
        logic [DW-1:0] bv;
        av = (r == k) ? 16'h0100 : 16'h0000;
        bv = DW'(k * 256 + r);
        a[r*DW +: DW] = neg ? -av : av;
        b[r*DW +: DW] = neg ? -bv : bv;
      end
      send_beat(a, b, k == N - 1);
    end
  endtask

  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", cyc, {srca, srcb, clear, in_ready, busy, done},
          {{(2*N*DW+N){1'b0}}, 3'b100});
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    send_beat({N{16'h0100}}, {N{16'h0100}}, 1'b1);
    idle(2*N + 3);

    ident_product(0, 1'b0, N);
    idle(2*N + 2);

    ident_product(3, 1'b0, N);
    idle(2*N + 2);

    for (int r = 0; r < N; r++) begin
      a[r*DW +: DW] = DW'(16 * (r + 1));
      b[r*DW +: DW] = DW'(32 * (r + 1));
    end
    send_beat(a, b, 1'b1);
    idle(2*N + 2);

    ident_product(0, 1'b0, 2);
    async_reset();
    send_beat({N{16'h0200}}, {N{16'h0080}}, 1'b1);
    idle(2*N + 2);

    ident_product(0, 1'b0, N);
    ident_product(0, 1'b1, N);
    idle(2*N + 2);

    repeat (20) begin
      int kk;
      kk = $urandom_range(1, 6);
      for (int k = 0; k < kk; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        for (int r = 0; r < N; r++) begin
          a[r*DW +: DW] = DW'($urandom);
          b[r*DW +: DW] = DW'($urandom);
        end
        send_beat(a, b, k == kk - 1);
      end
      idle($urandom_range(0, 2*N + 2));
    end

    idle(2*N + 4);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
